// File: rtl/rdma_inbound_unmap.sv
// Inbound RDMA responder: checks a remote address against the exported window,
// strips the window base, performs one local memory access and returns a status/data response.
module rdma_inbound_unmap #(
    parameter logic [31:0] OFFSET      = 32'h8000_0000,
    parameter logic [31:0] WINDOW_SIZE = 32'h1000_0000,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_remote_addr,
    input  logic        req_write,
    input  logic [31:0] req_wdata,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_status,
    output logic [31:0] rsp_rdata,
    output logic        busy
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TW = 16;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] ST_OK        = 2'b00;
    localparam logic [1:0] ST_WINDOW    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT   = 2'b10;
    localparam logic [1:0] ST_MISALIGN  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        ISSUE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    logic [AW-1:0]   addr_q;
    logic            write_q;
    logic [DW-1:0]   wdata_q;
    logic [TW-1:0]   timer;
    logic [AW-1:0]   diff_c;

    // Modular subtraction: addresses below OFFSET wrap to large values and fail the window test.
    assign diff_c = addr_q - OFFSET;

    // Request capture, window check, memory access and response handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            timer      <= '0;
            req_ready  <= 1'b0;
            mem_valid  <= 1'b0;
            mem_addr   <= '0;
            mem_write  <= 1'b0;
            mem_wdata  <= '0;
            rsp_valid  <= 1'b0;
            rsp_status <= ST_OK;
            rsp_rdata  <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (req_valid && req_ready) begin
                        addr_q    <= req_remote_addr;
                        write_q   <= req_write;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= CHECK;
                    end
                end

                CHECK: begin
                    timer <= '0;
                    if (addr_q[1:0] != 2'b00) begin
                        rsp_status <= ST_MISALIGN;
                        rsp_rdata  <= '0;
                        state      <= RESP;
                    end else if (diff_c >= WINDOW_SIZE) begin
                        rsp_status <= ST_WINDOW;
                        rsp_rdata  <= '0;
                        state      <= RESP;
                    end else begin
                        mem_addr  <= diff_c;
                        mem_write <= write_q;
                        mem_wdata <= wdata_q;
                        state     <= ISSUE;
                    end
                end

                // First ISSUE cycle raises mem_valid; acks only count once it is visible.
                ISSUE: begin
                    if (!mem_valid) begin
                        mem_valid <= 1'b1;
                    end else if (mem_ack) begin
                        mem_valid  <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_status <= ST_OK;
                        rsp_rdata  <= mem_write ? '0 : mem_rdata;
                        state      <= RESP;
                    end else if (timer == TIMER_LAST) begin
                        mem_valid  <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_status <= ST_TIMEOUT;
                        rsp_rdata  <= '0;
                        state      <= RESP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                RESP: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        rsp_status <= ST_OK;
                        rsp_rdata  <= '0;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
